regfile_bank: RTL and testbench

Parametrised general-purpose register file for the CPU datapath, generalised in data width and depth. It provides two combinational read ports and one synchronous write port. It adds three behaviours: an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending scoreboard for hazard detection. Array contents are not async-reset; a sweep-clear state machine zeroes the array one entry per cycle after reset or on request.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 77 +++++++
 rtl/regfile_bank.sv | 135 +++++++++++++
 tb/tb_regfile_bank.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing helper for the register file bank.
package regfile_pkg;

    // Array controller state: normal operation or sweep-clear in progress.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

    // Number of registers addressable with addr_w address bits.
    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard with set-over-clear priority and bypass masking.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_busy,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_reg,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_reg,
    input  logic [ADDR_W-1:0] i_rd_reg1,
    input  logic [ADDR_W-1:0] i_rd_reg2,
    output logic              o_pend1_c,
    output logic              o_pend2_c
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);
    localparam bit          ZR    = (ZERO_REG != 0);
    localparam bit          BP    = (BYPASS != 0);

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic             w_iss_en;

    // A claim is accepted only in normal operation and never for a hardwired zero register.
    assign w_iss_en = !i_busy && !i_clear && i_issue_valid
                      && !(ZR && (i_issue_reg == '0));

    // Next pending vector: clear-all, then write-clear, then issue-set so the newest producer wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_clear) begin
            w_pend_nxt = '0;
        end else begin
            if (i_wr_en) begin
                w_pend_nxt[i_wr_reg] = 1'b0;
            end
            if (w_iss_en) begin
                w_pend_nxt[i_issue_reg] = 1'b1;
            end
        end
    end

    // Pending vector register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Read-side pending flags; a same-cycle write hides the hazard unless it is re-claimed.
    always_comb begin
        o_pend1_c = 1'b0;
        o_pend2_c = 1'b0;
        if (!i_busy) begin
            o_pend1_c = r_pend[i_rd_reg1];
            o_pend2_c = r_pend[i_rd_reg2];
            if (BP && i_wr_en && (i_wr_reg == i_rd_reg1)
                && !(w_iss_en && (i_issue_reg == i_rd_reg1))) begin
                o_pend1_c = 1'b0;
            end
            if (BP && i_wr_en && (i_wr_reg == i_rd_reg2)
                && !(w_iss_en && (i_issue_reg == i_rd_reg2))) begin
                o_pend2_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Two-read/one-write register file with optional zero register, write bypass,
// pending scoreboard and a one-entry-per-cycle sweep-clear after reset or on request.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              regWrite,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    output logic              pending1,
    output logic              pending2,
    input  logic              clearReq,
    output logic              busy
);

    localparam int unsigned       DEPTH    = rf_depth(ADDR_W);
    localparam bit                ZR       = (ZERO_REG != 0);
    localparam bit                BP       = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_clr_start;
    logic w_wr_en;

    assign w_busy      = (r_state == ST_CLEAR);
    assign w_clr_start = !w_busy && clearReq;
    // Effective write: idle, not displaced by a clear, and not aimed at a hardwired zero.
    assign w_wr_en     = !w_busy && !clearReq && regWrite && !(ZR && (writeReg == '0));
    assign busy        = w_busy;

    // Controller state and sweep pointer; reset always restarts the sweep from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next-state: enter the sweep on request, leave it after the last entry is cleared.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clearReq) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (r_clr_ptr == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Storage array has no reset; the sweep zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[writeReg] <= writeData;
        end
    end

    // Combinational read ports with zero register and optional same-cycle forwarding.
    always_comb begin
        readData1 = r_mem[readReg1];
        readData2 = r_mem[readReg2];
        if (BP && w_wr_en && (writeReg == readReg1)) begin
            readData1 = writeData;
        end
        if (BP && w_wr_en && (writeReg == readReg2)) begin
            readData2 = writeData;
        end
        if (ZR && (readReg1 == '0)) begin
            readData1 = '0;
        end
        if (ZR && (readReg2 == '0)) begin
            readData2 = '0;
        end
        if (w_busy) begin
            readData1 = '0;
            readData2 = '0;
        end
    end

    // Hazard scoreboard.
    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_busy        (w_busy),
        .i_clear       (w_clr_start),
        .i_wr_en       (w_wr_en),
        .i_wr_reg      (writeReg),
        .i_issue_valid (issueValid),
        .i_issue_reg   (issueReg),
        .i_rd_reg1     (readReg1),
        .i_rd_reg2     (readReg2),
        .o_pend1_c     (pending1),
        .o_pend2_c     (pending2)
    );

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: two instances (zero-reg+bypass, and plain) share stimulus
// and are compared against an array-based reference model.
module tb_regfile_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] readReg1, readReg2, writeReg, issueReg;
    logic [DW-1:0] writeData;
    logic          regWrite, issueValid, clearReq;

    logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic          p1_a, p2_a, p1_b, p2_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: index 0 = instance a (zero reg, bypass), 1 = instance b (neither).
    logic [DW-1:0] m_mem  [2][DEPTH];
    bit            m_pend [2][DEPTH];
    int            m_left;

    always #5 clk = ~clk;

    regfile_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_a), .readData2(rd2_a),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .issueValid(issueValid), .issueReg(issueReg),
        .pending1(p1_a), .pending2(p2_a),
        .clearReq(clearReq), .busy(busy_a)
    );

    regfile_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_b), .readData2(rd2_b),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .issueValid(issueValid), .issueReg(issueReg),
        .pending1(p1_b), .pending2(p2_b),
        .clearReq(clearReq), .busy(busy_b)
    );

    function automatic bit zr(int d);
        return d == 0;
    endfunction

    function automatic bit bp(int d);
        return d == 0;
    endfunction

    function automatic bit m_eff_wr(int d);
        return (m_left == 0) && !reset && regWrite && !clearReq
               && !(zr(d) && writeReg == '0);
    endfunction

    function automatic logic [DW-1:0] m_read(int d, logic [AW-1:0] a);
        if (m_left != 0 || reset) return '0;
        if (zr(d) && a == '0) return '0;
        if (bp(d) && m_eff_wr(d) && writeReg == a) return writeData;
        return m_mem[d][a];
    endfunction

    function automatic bit m_pending(int d, logic [AW-1:0] a);
        if (m_left != 0 || reset) return 1'b0;
        if (bp(d) && m_eff_wr(d) && writeReg == a && !(issueValid && issueReg == a)) return 1'b0;
        return m_pend[d][a];
    endfunction

    task automatic m_zero();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                m_mem[d][i]  = '0;
                m_pend[d][i] = 1'b0;
            end
        end
    endtask

    // One clock edge: advance the model from the inputs present at the edge, return at negedge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_left = int'(DEPTH);
            m_zero();
        end else if (m_left != 0) begin
            m_left--;
        end else if (clearReq) begin
            m_left = int'(DEPTH);
            m_zero();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_eff_wr(d)) begin
                    m_mem[d][writeReg]  = writeData;
                    m_pend[d][writeReg] = 1'b0;
                end
                if (issueValid && !(zr(d) && issueReg == '0)) begin
                    m_pend[d][issueReg] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Run until busy drops (bounded); report cycles seen busy and reads that were not zero.
    task automatic wait_busy_low(output int cnt, output int bad_rd);
        cnt    = 0;
        bad_rd = 0;
        for (int c = 0; c < 40; c++) begin
            readReg1 = AW'($urandom_range(DEPTH - 1));
            readReg2 = AW'($urandom_range(DEPTH - 1));
            #1;
            if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
                regWrite = 1'b0;
                break;
            end
            cnt++;
            if (rd1_a !== '0 || rd2_b !== '0 || p1_a !== 1'b0 || p2_b !== 1'b0) bad_rd++;
            step();
        end
    endtask

    task automatic test_reset();
        int cnt, bad;
        reset = 1'b1; readReg1 = '0; readReg2 = '0; writeReg = '0; issueReg = '0;
        writeData = '0; regWrite = 1'b0; issueValid = 1'b0; clearReq = 1'b0;
        m_left = int'(DEPTH);
        m_zero();
        step(); step();
        #1;
        n_tests++;
        if (busy_a !== 1'b1 || rd1_a !== '0 || p1_a !== 1'b0 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rd1=%h p1=%b busy_b=%b, want busy=1 rd1=0 p1=0",
                     busy_a, rd1_a, p1_a, busy_b);
        end
        reset = 1'b0;
        wait_busy_low(cnt, bad);
        n_tests++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles, want 16", cnt);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_busy_outputs: %0d cycles with nonzero read/pending, want 0", bad);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            readReg1 = AW'(i);
            readReg2 = AW'(DEPTH - 1 - i);
            #1;
            n_tests++;
            if (rd1_a !== '0 || rd2_a !== '0 || rd1_b !== '0 || rd2_b !== '0) begin
                n_fail++;
                $display("FAIL post_sweep_zero r%0d: a=%h/%h b=%h/%h, want 0", i, rd1_a, rd2_a, rd1_b, rd2_b);
            end
            step();
        end
    endtask

    task automatic test_write_read();
        writeReg = 4'd5; writeData = 32'hDEADBEEF; regWrite = 1'b1;
        step();
        regWrite = 1'b0; readReg1 = 4'd5; readReg2 = 4'd5;
        #1;
        n_tests++;
        if (rd1_a !== 32'hDEADBEEF || rd2_a !== 32'hDEADBEEF
            || rd1_b !== 32'hDEADBEEF || rd2_b !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read_r5: a=%h/%h b=%h/%h, want deadbeef", rd1_a, rd2_a, rd1_b, rd2_b);
        end
        step();
        writeReg = 4'd0; writeData = 32'h1234; regWrite = 1'b1;
        step();
        regWrite = 1'b0; readReg1 = 4'd0;
        #1;
        n_tests++;
        if (rd1_a !== '0) begin
            n_fail++;
            $display("FAIL zero_reg_a: got %h, want 0", rd1_a);
        end
        n_tests++;
        if (rd1_b !== 32'h1234) begin
            n_fail++;
            $display("FAIL r0_writable_b: got %h, want 00001234", rd1_b);
        end
        step();
    endtask

    task automatic test_bypass();
        writeReg = 4'd7; writeData = 32'h0BADF00D; regWrite = 1'b1;
        step();
        writeData = 32'hA5A5A5A5; readReg1 = 4'd7;
        #1;
        n_tests++;
        if (rd1_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h, want a5a5a5a5", rd1_a);
        end
        n_tests++;
        if (rd1_b !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL nobypass_old_value: got %h, want 0badf00d", rd1_b);
        end
        step();
        regWrite = 1'b0;
        #1;
        n_tests++;
        if (rd1_b !== 32'hA5A5A5A5 || rd1_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: a=%h b=%h, want a5a5a5a5", rd1_a, rd1_b);
        end
        step();
    endtask

    task automatic test_scoreboard();
        issueValid = 1'b1; issueReg = 4'd3; readReg2 = 4'd3;
        step();
        issueValid = 1'b0;
        #1;
        n_tests++;
        if (p2_a !== 1'b1 || p2_b !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_sets_pending: a=%b b=%b, want 1", p2_a, p2_b);
        end
        writeReg = 4'd3; writeData = $urandom; regWrite = 1'b1;
        #1;
        n_tests++;
        if (p2_a !== 1'b0 || p2_b !== 1'b1) begin
            n_fail++;
            $display("FAIL write_masks_pending: a=%b b=%b, want a=0 b=1", p2_a, p2_b);
        end
        step();
        regWrite = 1'b0;
        #1;
        n_tests++;
        if (p2_a !== 1'b0 || p2_b !== 1'b0) begin
            n_fail++;
            $display("FAIL write_clears_pending: a=%b b=%b, want 0", p2_a, p2_b);
        end
        issueValid = 1'b1; issueReg = 4'd3; regWrite = 1'b1; writeReg = 4'd3;
        step();
        issueValid = 1'b0; regWrite = 1'b0;
        #1;
        n_tests++;
        if (p2_a !== 1'b1 || p2_b !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: a=%b b=%b, want 1", p2_a, p2_b);
        end
        issueValid = 1'b1; issueReg = 4'd0; readReg1 = 4'd0;
        step();
        issueValid = 1'b0;
        #1;
        n_tests++;
        if (p1_a !== 1'b0 || p1_b !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_r0: a=%b b=%b, want a=0 b=1", p1_a, p1_b);
        end
        step();
    endtask

    task automatic test_clear_wins();
        int cnt, bad;
        writeReg = 4'd9; writeData = 32'h11; regWrite = 1'b1;
        step();
        regWrite = 1'b0; readReg1 = 4'd9;
        #1;
        n_tests++;
        if (rd1_a !== 32'h11) begin
            n_fail++;
            $display("FAIL clear_pre_r9: got %h, want 00000011", rd1_a);
        end
        clearReq = 1'b1; regWrite = 1'b1; writeReg = 4'd9; writeData = 32'hFF;
        step();
        clearReq = 1'b0; regWrite = 1'b0;
        wait_busy_low(cnt, bad);
        n_tests++;
        if (cnt != 16 || bad != 0) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles (%0d bad), want 16 (0 bad)", cnt, bad);
        end
        readReg1 = 4'd9; readReg2 = 4'd9;
        #1;
        n_tests++;
        if (rd1_a !== '0 || rd1_b !== '0) begin
            n_fail++;
            $display("FAIL clear_drops_write: a=%h b=%h, want 0", rd1_a, rd1_b);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            readReg1 = AW'(i);
            readReg2 = AW'(i);
            #1;
            n_tests++;
            if (p1_a !== 1'b0 || p2_b !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_pending r%0d: a=%b b=%b, want 0", i, p1_a, p2_b);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt, bad;
        writeReg = 4'd2; writeData = 32'h77; regWrite = 1'b1;
        step();
        regWrite = 1'b0; clearReq = 1'b1;
        step();
        clearReq = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        m_left = int'(DEPTH);
        m_zero();
        regWrite = 1'b1; writeReg = 4'd2; writeData = 32'hCAFE;
        #1;
        n_tests++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_reset_busy: a=%b b=%b, want 1", busy_a, busy_b);
        end
        step(); step();
        reset = 1'b0;
        wait_busy_low(cnt, bad);
        n_tests++;
        if (cnt != 16 || bad != 0) begin
            n_fail++;
            $display("FAIL midsweep_restart_len: got %0d cycles (%0d bad), want 16 (0 bad)", cnt, bad);
        end
        readReg1 = 4'd2;
        #1;
        n_tests++;
        if (rd1_a !== '0 || rd1_b !== '0) begin
            n_fail++;
            $display("FAIL busy_write_ignored: a=%h b=%h, want 0", rd1_a, rd1_b);
        end
        step();
    endtask

    task automatic test_random();
        logic [DW-1:0] r1 [2];
        logic [DW-1:0] r2 [2];
        logic          q1 [2];
        logic          q2 [2];
        logic          bz [2];
        for (int c = 0; c < 600; c++) begin
            regWrite   = ($urandom_range(1) == 1);
            issueValid = ($urandom_range(9) < 3);
            clearReq   = ($urandom_range(79) == 0);
            writeReg   = AW'($urandom_range(DEPTH - 1));
            issueReg   = ($urandom_range(3) == 0) ? writeReg : AW'($urandom_range(DEPTH - 1));
            readReg1   = ($urandom_range(3) == 0) ? writeReg : AW'($urandom_range(DEPTH - 1));
            readReg2   = ($urandom_range(3) == 0) ? issueReg : AW'($urandom_range(DEPTH - 1));
            writeData  = $urandom;
            #1;
            r1[0] = rd1_a; r2[0] = rd2_a; q1[0] = p1_a; q2[0] = p2_a; bz[0] = busy_a;
            r1[1] = rd1_b; r2[1] = rd2_b; q1[1] = p1_b; q2[1] = p2_b; bz[1] = busy_b;
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (bz[d] !== (m_left != 0)) begin
                    n_fail++;
                    $display("FAIL rand_busy dut%0d cyc%0d: got %b want %b", d, c, bz[d], m_left != 0);
                end
                n_tests++;
                if (r1[d] !== m_read(d, readReg1)) begin
                    n_fail++;
                    $display("FAIL rand_rd1 dut%0d cyc%0d: got %h want %h", d, c, r1[d], m_read(d, readReg1));
                end
                n_tests++;
                if (r2[d] !== m_read(d, readReg2)) begin
                    n_fail++;
                    $display("FAIL rand_rd2 dut%0d cyc%0d: got %h want %h", d, c, r2[d], m_read(d, readReg2));
                end
                n_tests++;
                if (q1[d] !== m_pending(d, readReg1)) begin
                    n_fail++;
                    $display("FAIL rand_pend1 dut%0d cyc%0d: got %b want %b", d, c, q1[d], m_pending(d, readReg1));
                end
                n_tests++;
                if (q2[d] !== m_pending(d, readReg2)) begin
                    n_fail++;
                    $display("FAIL rand_pend2 dut%0d cyc%0d: got %b want %b", d, c, q2[d], m_pending(d, readReg2));
                end
            end
            step();
        end
        regWrite = 1'b0; issueValid = 1'b0; clearReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_clear_wins();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a wait never returns.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
